// File: rtl/regfile_demux_1x16.sv
// regfile_demux_1x16
// Write side of the 16-entry register file. A single write request per cycle
// is taken over a valid/ready handshake and parked in a one-deep pending stage.
// From there it is committed into one of 16 registers through a one-hot decode.
// The whole array is exported packed, so the 16:1 read muxes can select from it.
//
// Build option: REGFILE_ZERO_REG_EN
//   defined     - register 15 is hardwired to zero. Writes to it are accepted
//                 but dropped at commit, and the one-hot bit 15 never fires.
//   not defined - all 16 registers are general purpose.
module regfile_demux_1x16 #(
  parameter int INPUT_LENGTH = 64,
  parameter int INPUT_WIDTH  = 16,
  parameter int SELECT_WIDTH = $clog2(INPUT_WIDTH)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_ni,
  input  logic                                     wr_valid_i,
  output logic                                     wr_ready_o,
  input  logic [SELECT_WIDTH-1:0]                  wr_addr_i,
  input  logic [INPUT_LENGTH-1:0]                  wr_data_i,
  input  logic                                     stall_i,
  output logic [INPUT_WIDTH-1:0][INPUT_LENGTH-1:0] regs_o,
  output logic [INPUT_WIDTH-1:0]                   wr_onehot_o,
  output logic                                     pending_o
);

  // Pending stage and register array state
  logic                                     pend_r;
  logic [SELECT_WIDTH-1:0]                  pend_addr_r;
  logic [INPUT_LENGTH-1:0]                  pend_data_r;
  logic [INPUT_WIDTH-1:0][INPUT_LENGTH-1:0] regs_r;
  logic [INPUT_WIDTH-1:0]                   onehot_r;

  // Per-cycle handshake and commit controls
  logic                   ready_s;
  logic                   accept_s;
  logic                   commit_s;
  logic [INPUT_WIDTH-1:0] commit_en_s;

  // Binary address to one-hot enable; every address value is legal.
  function automatic logic [INPUT_WIDTH-1:0] decode_onehot(
    input logic [SELECT_WIDTH-1:0] addr
  );
    logic [INPUT_WIDTH-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

  // Handshake: the stage can take a new entry when it is empty, or when it
  // drains at this edge.
  always_comb begin
    ready_s  = 1'b0;
    accept_s = 1'b0;
    commit_s = 1'b0;
    if (!pend_r || !stall_i) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    if (pend_r && !stall_i) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
    if (wr_valid_i && ready_s) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Commit enables: decode the pending address, and mask register 15 when it is
  // the hardwired zero register.
  always_comb begin
    commit_en_s = '0;
    if (commit_s) begin
      commit_en_s = decode_onehot(pend_addr_r);
    end else begin
      commit_en_s = '0;
    end
`ifdef REGFILE_ZERO_REG_EN
    commit_en_s[INPUT_WIDTH-1] = 1'b0;
`endif
  end

  // Pending stage: load on accept, clear on a commit with nothing new behind it,
  // and hold otherwise (including while stalled).
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pend_r      <= 1'b0;
      pend_addr_r <= '0;
      pend_data_r <= '0;
    end else if (accept_s) begin
      pend_r      <= 1'b1;
      pend_addr_r <= wr_addr_i;
      pend_data_r <= wr_data_i;
    end else if (commit_s) begin
      pend_r      <= 1'b0;
    end
  end

  // Register array: the pending entry writes the single enabled register.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      regs_r <= '0;
    end else begin
      for (int i = 0; i < INPUT_WIDTH; i++) begin
        if (commit_en_s[i]) begin
          regs_r[i] <= pend_data_r;
        end
      end
    end
  end

  // One-hot commit pulse. It lines up with the first cycle in which the new
  // value is visible on regs_o.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      onehot_r <= '0;
    end else begin
      onehot_r <= commit_en_s;
    end
  end

  assign wr_ready_o  = ready_s;
  assign pending_o   = pend_r;
  assign wr_onehot_o = onehot_r;
  assign regs_o      = regs_r;

endmodule

// File: tb/tb_regfile_demux_1x16.sv
// Testbench for regfile_demux_1x16. It applies directed vectors from a table,
// followed by a hand-written 16-address streaming sequence.
module tb_regfile_demux_1x16;

  logic                  clk;
  logic                  reset_ni;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [3:0]            wr_addr;
  logic [63:0]           wr_data;
  logic                  stall;
  logic [15:0][63:0]     regs;
  logic [15:0]           wr_onehot;
  logic                  pending;

  int tests_run;
  int tests_failed;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [15:0] R15_OH  = 16'h0000;
  localparam logic [63:0] R15_VAL = 64'h0;
  localparam logic [63:0] R15_STREAM = 64'h0;
`else
  localparam logic [15:0] R15_OH  = 16'h8000;
  localparam logic [63:0] R15_VAL = 64'hFF;
  localparam logic [63:0] R15_STREAM = 64'd16;
`endif

  regfile_demux_1x16 dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .stall_i     (stall),
    .regs_o      (regs),
    .wr_onehot_o (wr_onehot),
    .pending_o   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  a;
    logic [63:0] d;
    logic        s;
    logic        r;
    logic        rdy;
    logic        pend;
    logic [15:0] oh;
    logic [3:0]  idx;
    logic [63:0] rv;
    logic        others;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic v, input logic [3:0] a,
                              input logic [63:0] d, input logic s,
                              input logic r, input logic rdy,
                              input logic pend, input logic [15:0] oh,
                              input logic [3:0] idx, input logic [63:0] rv,
                              input logic others);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.s = s; t.r = r; t.rdy = rdy;
    t.pend = pend; t.oh = oh; t.idx = idx; t.rv = rv; t.others = others;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_ni = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 64'd0;
    stall    = 1'b0;

    // columns: v, a, d, s, r | rdy, pend, oh, idx, reg value, others-zero
    tbl[0]  = mk(1'b1, 4'd3,  64'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'd3,  64'h0,         1'b0);
    tbl[1]  = mk(1'b0, 4'd0,  64'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'h0008, 4'd3,  64'hDEAD_BEEF, 1'b1);
    tbl[2]  = mk(1'b0, 4'd0,  64'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd3,  64'hDEAD_BEEF, 1'b0);
    tbl[3]  = mk(1'b1, 4'd5,  64'h11,        1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'd5,  64'h0,         1'b0);
    tbl[4]  = mk(1'b1, 4'd6,  64'h22,        1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd5,  64'h0,         1'b0);
    tbl[5]  = mk(1'b1, 4'd6,  64'h22,        1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd5,  64'h0,         1'b0);
    tbl[6]  = mk(1'b1, 4'd6,  64'h22,        1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd5,  64'h0,         1'b0);
    tbl[7]  = mk(1'b1, 4'd6,  64'h22,        1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 4'd5,  64'h11,        1'b0);
    tbl[8]  = mk(1'b0, 4'd0,  64'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 4'd6,  64'h22,        1'b0);
    tbl[9]  = mk(1'b0, 4'd0,  64'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd5,  64'h11,        1'b0);
    tbl[10] = mk(1'b1, 4'd7,  64'hAA,        1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'd7,  64'h0,         1'b0);
    tbl[11] = mk(1'b1, 4'd7,  64'hBB,        1'b0, 1'b1, 1'b1, 1'b1, 16'h0080, 4'd7,  64'hAA,        1'b0);
    tbl[12] = mk(1'b0, 4'd0,  64'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'h0080, 4'd7,  64'hBB,        1'b0);
    tbl[13] = mk(1'b0, 4'd0,  64'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd7,  64'hBB,        1'b0);
    tbl[14] = mk(1'b1, 4'd9,  64'h55,        1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'd9,  64'h0,         1'b0);
    tbl[15] = mk(1'b0, 4'd0,  64'h0,         1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd9,  64'h0,         1'b0);
    tbl[16] = mk(1'b0, 4'd0,  64'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd7,  64'h0,         1'b1);
    tbl[17] = mk(1'b1, 4'd15, 64'hFF,        1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'd15, 64'h0,         1'b0);
    tbl[18] = mk(1'b0, 4'd0,  64'h0,         1'b0, 1'b1, 1'b1, 1'b0, R15_OH,   4'd15, R15_VAL,       1'b0);
    tbl[19] = mk(1'b0, 4'd0,  64'h0,         1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd15, R15_VAL,       1'b0);
    tbl[20] = mk(1'b0, 4'd0,  64'h0,         1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd15, R15_VAL,       1'b0);

    // Reset state
    step();
    step();
    chk("reset_pending", {63'd0, pending}, 64'd0);
    chk("reset_onehot", {48'd0, wr_onehot}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("reset_reg%0d", i), regs[i], 64'd0);
    end
    reset_ni = 1'b1;
    #1;
    chk("reset_ready", {63'd0, wr_ready}, 64'd1);

    // Table-driven vectors
    for (int k = 0; k < 21; k++) begin
      wr_valid = tbl[k].v;
      wr_addr  = tbl[k].a;
      wr_data  = tbl[k].d;
      stall    = tbl[k].s;
      reset_ni = tbl[k].r;
      #1;
      chk($sformatf("v%0d_ready", k), {63'd0, wr_ready}, {63'd0, tbl[k].rdy});
      step();
      chk($sformatf("v%0d_pending", k), {63'd0, pending}, {63'd0, tbl[k].pend});
      chk($sformatf("v%0d_onehot", k), {48'd0, wr_onehot}, {48'd0, tbl[k].oh});
      chk($sformatf("v%0d_reg%0d", k, tbl[k].idx), regs[tbl[k].idx], tbl[k].rv);
      if (tbl[k].others) begin
        for (int j = 0; j < 16; j++) begin
          if (j != int'(tbl[k].idx)) begin
            chk($sformatf("v%0d_zero_reg%0d", k, j), regs[j], 64'd0);
          end
        end
      end
    end
    reset_ni = 1'b1;
    stall    = 1'b0;

    // Streaming: addresses 0..15, data addr+1, on consecutive cycles
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 4'(i);
      wr_data  = 64'(i + 1);
      #1;
      chk($sformatf("stream_ready%0d", i), {63'd0, wr_ready}, 64'd1);
      step();
      if (i > 0) begin
        chk($sformatf("stream_oh%0d", i - 1), {48'd0, wr_onehot},
            {48'd0, 16'(16'h0001 << (i - 1))});
        chk($sformatf("stream_reg%0d", i - 1), regs[i - 1], 64'(i));
      end
    end
    wr_valid = 1'b0;
    step();
    chk("stream_oh15", {48'd0, wr_onehot}, {48'd0, R15_OH});
    chk("stream_reg15", regs[15], R15_STREAM);
    chk("stream_pending", {63'd0, pending}, 64'd0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("stream_final_reg%0d", i), regs[i], 64'(i + 1));
    end
    step();
    chk("stream_oh_idle", {48'd0, wr_onehot}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_demux_1x16.md
# regfile_demux_1x16

Write-side counterpart of the 16:1 register read multiplexer: accepts one N-bit write request per cycle over a valid/ready handshake, buffers it in a one-deep pending stage, decodes the 4-bit address to a one-hot enable, and commits the data into one of 16 N-bit registers. The full register array is exported packed so the 16x1 read muxes can select from it directly. It sits between writeback and the register-read stage of the CPU datapath.

## Interface
- `INPUT_LENGTH`, 64, width of each register and of write data.
- `INPUT_WIDTH`, 16, number of registers; fixed at 16.
- `SELECT_WIDTH`, `$clog2(INPUT_WIDTH)` = 4, write address width.

- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_ni`  in  1  synchronous, active-low reset.
- `wr_valid_i`  in  1  write request valid.
- `wr_ready_o`  out  1  block can accept a request this cycle.
- `wr_addr_i`  in  SELECT_WIDTH  destination register index.
- `wr_data_i`  in  INPUT_LENGTH  write data.
- `stall_i`  in  1  holds the pending write uncommitted.
- `regs_o`  out  [INPUT_WIDTH-1:0][INPUT_LENGTH-1:0]  all register contents, packed, index 0 in the low slot.
- `wr_onehot_o`  out  INPUT_WIDTH  one-hot of the register written on the previous edge; all-zero otherwise.
- `pending_o`  out  1  pending stage holds an uncommitted write.

## Operation
- State: pending flag `pend_q`, pending address/data, 16-entry register array, `wr_onehot_o` register.
- Accept: `wr_valid_i && wr_ready_o` at an edge loads address/data into the pending stage and sets `pend_q`.
- `wr_ready_o = !pend_q || !stall_i` (combinational). The stage is free, or it drains this edge.
- Commit: at each edge with `pend_q && !stall_i`, `regs[pend_addr] <= pend_data`, and `wr_onehot_o <= 1 << pend_addr`. Otherwise `wr_onehot_o <= 0`.
- Commit and accept in the same edge are legal. The old entry commits and the new entry loads, so `pend_q` stays 1.
- Commit without accept clears `pend_q`.
- Stall with pending: the entry, `pend_q` and the registers hold; `wr_ready_o` = 0; `wr_valid_i` is ignored and the requester must hold it.
- Back-to-back writes to the same address commit in acceptance order, so the last accepted value wins.
- Address decode covers all 16 values; there is no illegal address.
- `regs_o` is driven directly from the array register outputs; there is no combinational bypass from `wr_data_i` or the pending stage.

## Timing
- Reset (`reset_ni` = 0 at an edge) sets all registers to 0, `pend_q` to 0, and `wr_onehot_o` to 0.
- After reset, `wr_ready_o` = 1 and `pending_o` = 0.
- Reset overrides accept and commit in the same edge; a pending write is discarded mid-operation.
- Latency: a request accepted at edge k appears on `regs_o` after edge k+1, provided `stall_i` = 0 in the cycle before k+1. Each stalled cycle adds one cycle.
- Throughput: one write per cycle with `stall_i` low.
- `wr_onehot_o` is a single-cycle pulse per commit, aligned with the cycle in which the new value is first visible on `regs_o`.

## Configuration
- `REGFILE_ZERO_REG_EN`:
  - Defined: register 15 is hardwired zero. Writes to address 15 are accepted and pass through the pending stage, but are discarded at commit. `wr_onehot_o[15]` never asserts, and `regs_o[15]` is constant 0.
  - Not defined: all 16 registers are general-purpose.

## Test plan
- Reset, then write addr 3 data `64'hDEAD_BEEF` with `stall_i` = 0 -> `wr_ready_o` = 1; `regs_o[3]` = `DEAD_BEEF` and `wr_onehot_o` = `16'h0008` in the cycle after the commit edge; all other registers read 0.
- Stream writes to addresses 0..15 with data = addr+1 on 16 consecutive cycles -> `wr_ready_o` stays 1; each register i reads i+1; one-hot pulses walk 0x0001..0x8000.
- Accept addr 5 = `0x11`, raise `stall_i` for 3 cycles while driving addr 6 = `0x22` valid -> `wr_ready_o` = 0 and `pending_o` = 1 throughout; `regs_o[5]` stays 0. Drop stall -> 5 commits `0x11`, then 6 commits `0x22` on the next edge.
- Back-to-back writes to addr 7: `0xAA` then `0xBB` -> final `regs_o[7]` = `0xBB`; two one-hot pulses of `0x0080`.
- Accept addr 9 = `0x55`, assert `reset_ni` = 0 on the commit edge -> `regs_o[9]` = 0, `pending_o` = 0, `wr_onehot_o` = 0.
- With `REGFILE_ZERO_REG_EN` defined, write addr 15 = `0xFF` -> `regs_o[15]` = 0 and `wr_onehot_o` = 0. Without the macro -> `regs_o[15]` = `0xFF` and `wr_onehot_o` = `0x8000`.
